// File: rtl/psola_window_streamer.sv
// Ping-pong window buffer between the PSOLA synthesis core and the audio output stage.
// Captures finished windows into one of two banks and plays them back one word per sample tick.
module psola_window_streamer #(
    parameter int WINDOW_SIZE  = 2048,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAC_BITS    = 10
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic signed [31:0]             window_in [2*WINDOW_SIZE],
    input  logic [11:0]                    window_len_in,
    input  logic                           window_done_in,
    output logic                           capture_busy_out,
    input  logic                           sample_tick_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic                           playing_out,
    output logic                           underrun_out,
    output logic                           overflow_out
);
    localparam int DEPTH = 2 * WINDOW_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam logic signed [31:0] S_MAX = (32'sd1 <<< (SAMPLE_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] S_MIN = -(32'sd1 <<< (SAMPLE_WIDTH - 1));

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_PLAYING} bank_st_e;
    typedef enum logic {C_IDLE, C_COPY} cap_st_e;
    typedef enum logic {P_IDLE, P_PLAY} play_st_e;

    cap_st_e             cap_st_q, cap_st_d;
    logic                cap_bank_q, cap_bank_d;
    logic [AW-1:0]       wr_idx_q, wr_idx_d;
    play_st_e            play_st_q, play_st_d;
    logic                play_bank_q, play_bank_d;
    logic [AW-1:0]       rd_idx_q, rd_idx_d;
    bank_st_e [1:0]      bank_st_q, bank_st_d;
    logic [1:0][LW-1:0]  bank_len_q, bank_len_d;
    logic                oldest_q, oldest_d;
    logic                ovf_q, ovf_d;

    logic [1:0]          wr_en, freed;
    logic [AW-1:0]       rd_addr;
    logic                rd_req, rd_unf, rd_bank_d;
    logic                rd_vld_q, rd_unf_q, rd_bank_q;
    logic                valid_q, unf_q;
    logic signed [SAMPLE_WIDTH-1:0] sample_q, sat_val;
    logic                pick, any_full, new_win, tgt_bank, tgt_ok;
    logic [LW-1:0]       len_clamped;
    logic signed [31:0]  rd_word, shifted;

    always_comb begin
        if ({20'd0, window_len_in} > 32'(DEPTH)) len_clamped = LW'(DEPTH);
        else                                     len_clamped = LW'(window_len_in);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic signed [31:0] mem [DEPTH];
        logic signed [31:0] rd_q;
        always_ff @(posedge clk_in) begin
            if (wr_en[b]) mem[wr_idx_q] <= window_in[wr_idx_q];
            rd_q <= mem[rd_addr];
        end
    end

    always_comb begin
        cap_st_d    = cap_st_q;
        cap_bank_d  = cap_bank_q;
        wr_idx_d    = wr_idx_q;
        play_st_d   = play_st_q;
        play_bank_d = play_bank_q;
        rd_idx_d    = rd_idx_q;
        bank_st_d   = bank_st_q;
        bank_len_d  = bank_len_q;
        oldest_d    = oldest_q;
        ovf_d       = 1'b0;
        wr_en       = '0;
        freed       = '0;
        rd_req      = 1'b0;
        rd_unf      = 1'b0;
        rd_addr     = rd_idx_q;
        rd_bank_d   = play_bank_q;
        any_full    = (bank_st_q[0] == B_FULL) || (bank_st_q[1] == B_FULL);
        pick        = ((bank_st_q[0] == B_FULL) && (bank_st_q[1] == B_FULL)) ? oldest_q
                                                                           : (bank_st_q[1] == B_FULL);
        new_win     = window_done_in && (window_len_in != 12'd0);

        case (play_st_q)
            P_IDLE: if (sample_tick_in) begin
                rd_req = 1'b1;
                if (any_full) begin
                    rd_addr     = '0;
                    rd_bank_d   = pick;
                    play_bank_d = pick;
                    if (bank_len_q[pick] == LW'(1)) begin
                        bank_st_d[pick] = B_EMPTY;
                        freed[pick]     = 1'b1;
                    end else begin
                        bank_st_d[pick] = B_PLAYING;
                        rd_idx_d        = AW'(1);
                        play_st_d       = P_PLAY;
                    end
                end else begin
                    rd_unf = 1'b1;
                end
            end
            P_PLAY: if (sample_tick_in) begin
                rd_req = 1'b1;
                if (LW'(rd_idx_q) == bank_len_q[play_bank_q] - LW'(1)) begin
                    bank_st_d[play_bank_q] = B_EMPTY;
                    freed[play_bank_q]     = 1'b1;
                    rd_idx_d               = '0;
                    play_st_d              = P_IDLE;
                end else begin
                    rd_idx_d = rd_idx_q + AW'(1);
                end
            end
            default: play_st_d = P_IDLE;
        endcase

        // A bank released by playback this cycle counts as free for a new capture.
        tgt_ok   = (bank_st_q[0] == B_EMPTY) || freed[0] || (bank_st_q[1] == B_EMPTY) || freed[1];
        tgt_bank = !((bank_st_q[0] == B_EMPTY) || freed[0]);

        case (cap_st_q)
            C_IDLE: if (new_win) begin
                if (tgt_ok) begin
                    cap_bank_d           = tgt_bank;
                    bank_st_d[tgt_bank]  = B_FILLING;
                    bank_len_d[tgt_bank] = len_clamped;
                    wr_idx_d             = '0;
                    cap_st_d             = C_COPY;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            C_COPY: begin
                wr_en[cap_bank_q] = 1'b1;
                if (new_win) ovf_d = 1'b1;
                if (LW'(wr_idx_q) == bank_len_q[cap_bank_q] - LW'(1)) begin
                    bank_st_d[cap_bank_q] = B_FULL;
                    wr_idx_d              = '0;
                    cap_st_d              = C_IDLE;
                    if (bank_st_q[~cap_bank_q] != B_FULL) oldest_d = cap_bank_q;
                end else begin
                    wr_idx_d = wr_idx_q + AW'(1);
                end
            end
            default: cap_st_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cap_st_q    <= C_IDLE;
            cap_bank_q  <= 1'b0;
            wr_idx_q    <= '0;
            play_st_q   <= P_IDLE;
            play_bank_q <= 1'b0;
            rd_idx_q    <= '0;
            bank_st_q   <= {B_EMPTY, B_EMPTY};
            bank_len_q  <= '0;
            oldest_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cap_st_q    <= cap_st_d;
            cap_bank_q  <= cap_bank_d;
            wr_idx_q    <= wr_idx_d;
            play_st_q   <= play_st_d;
            play_bank_q <= play_bank_d;
            rd_idx_q    <= rd_idx_d;
            bank_st_q   <= bank_st_d;
            bank_len_q  <= bank_len_d;
            oldest_q    <= oldest_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rd_word = rd_bank_q ? g_bank[1].rd_q : g_bank[0].rd_q;
    assign shifted = rd_word >>> FRAC_BITS;

    always_comb begin
        if (shifted > S_MAX)      sat_val = SAMPLE_WIDTH'(S_MAX);
        else if (shifted < S_MIN) sat_val = SAMPLE_WIDTH'(S_MIN);
        else                      sat_val = SAMPLE_WIDTH'(shifted);
    end

    // Stage 1 is the RAM read, stage 2 the scale/saturate register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_vld_q  <= 1'b0;
            rd_unf_q  <= 1'b0;
            rd_bank_q <= 1'b0;
            valid_q   <= 1'b0;
            unf_q     <= 1'b0;
            sample_q  <= '0;
        end else begin
            rd_vld_q  <= rd_req;
            rd_unf_q  <= rd_unf;
            rd_bank_q <= rd_bank_d;
            valid_q   <= rd_vld_q;
            unf_q     <= rd_vld_q && rd_unf_q;
            if (rd_vld_q) sample_q <= rd_unf_q ? '0 : sat_val;
        end
    end

    assign capture_busy_out = (cap_st_q == C_COPY);
    assign playing_out      = (play_st_q == P_PLAY);
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign underrun_out     = unf_q;
    assign overflow_out     = ovf_q;
endmodule

// File: tb/tb_psola_window_streamer.sv
// Directed bench for psola_window_streamer; expected samples are queued per tick and
// checked by a negedge monitor when sample_valid_out fires.
module tb_psola_window_streamer;
    localparam int WS    = 1024;
    localparam int DEPTH = 2 * WS;

    logic               clk_in = 1'b0;
    logic               rst_n_in = 1'b0;
    logic signed [31:0] win [DEPTH];
    logic [11:0]        len_i = '0;
    logic               done_i = 1'b0;
    logic               tick_i = 1'b0;
    logic               busy_o, valid_o, playing_o, unf_o, ovf_o;
    logic signed [15:0] sample_o;

    typedef struct {
        logic signed [15:0] s;
        logic               u;
    } exp_t;
    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    psola_window_streamer #(.WINDOW_SIZE(WS), .SAMPLE_WIDTH(16), .FRAC_BITS(10)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .window_in        (win),
        .window_len_in    (len_i),
        .window_done_in   (done_i),
        .capture_busy_out (busy_o),
        .sample_tick_in   (tick_i),
        .sample_out       (sample_o),
        .sample_valid_out (valid_o),
        .playing_out      (playing_o),
        .underrun_out     (unf_o),
        .overflow_out     (ovf_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic push(input int s, input bit u);
        exp_t e;
        e.s = 16'(s);
        e.u = u;
        q.push_back(e);
    endtask

    task automatic do_tick(input int s, input bit u);
        push(s, u);
        @(posedge clk_in); #1 tick_i = 1'b1;
        @(posedge clk_in); #1 tick_i = 1'b0;
        repeat (2) @(posedge clk_in);
    endtask

    task automatic pulse_done(input int len);
        @(posedge clk_in); #1;
        len_i  = 12'(len);
        done_i = 1'b1;
        @(posedge clk_in); #1 done_i = 1'b0;
    endtask

    task automatic send(input int len);
        int n;
        pulse_done(len);
        n = 0;
        while (busy_o && n < 5000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 5000) chk("capture_timeout", busy_o, 0);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in) begin
            if (valid_o) begin
                chk("scoreboard_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("sample", sample_o, e.s);
                    chk("underrun", unf_o, e.u);
                end
            end else if (unf_o) begin
                chk("underrun_without_valid", unf_o, 0);
            end
        end
    end

    initial begin
        int cnt;
        for (int k = 0; k < DEPTH; k++) win[k] = '0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_sample", sample_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_playing", playing_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_unf", unf_o, 0);
        @(negedge clk_in) rst_n_in = 1'b1;

        // Underrun before any capture, with exact T+2 timing
        push(0, 1'b1);
        @(posedge clk_in); #1 tick_i = 1'b1;
        @(posedge clk_in); #1 tick_i = 1'b0;
        @(negedge clk_in);
        chk("t2_valid_t1", valid_o, 0);
        @(negedge clk_in);
        chk("t2_valid_t2", valid_o, 1);
        chk("t2_unf_t2", unf_o, 1);
        chk("t2_playing", playing_o, 0);
        repeat (2) @(posedge clk_in);

        // Capture and scale, with busy width
        win[0] = 32'sd1024; win[1] = 32'sd2048; win[2] = -32'sd1024; win[3] = 32'h7FFF_FC00;
        pulse_done(4);
        cnt = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (busy_o) cnt++;
        end
        chk("t1_busy_cycles", cnt, 4);
        chk("t1_ovf", ovf_o, 0);
        do_tick(1, 0);
        chk("t1_playing", playing_o, 1);
        do_tick(2, 0);
        do_tick(-1, 0);
        do_tick(32767, 0);
        chk("t1_playing_done", playing_o, 0);

        // Back-to-back windows
        win[0] = 32'sd1024; win[1] = 32'sd2048; win[2] = 32'sd3072;
        send(3);
        win[0] = -32'sd2048; win[1] = -32'sd3072;
        send(2);
        do_tick(1, 0); do_tick(2, 0); do_tick(3, 0);
        do_tick(-2, 0); do_tick(-3, 0);
        do_tick(0, 1);

        // Overflow on third window
        win[0] = 32'sd1024; win[1] = 32'sd2048;
        send(2);
        win[0] = 32'sd3072; win[1] = 32'sd4096;
        send(2);
        win[0] = 32'sd5120; win[1] = 32'sd6144;
        pulse_done(2);
        @(negedge clk_in);
        chk("t4_ovf_pulse", ovf_o, 1);
        chk("t4_busy", busy_o, 0);
        @(negedge clk_in);
        chk("t4_ovf_single", ovf_o, 0);
        do_tick(1, 0); do_tick(2, 0); do_tick(3, 0); do_tick(4, 0);
        do_tick(0, 1);

        // Negative saturation and floor rounding
        win[0] = 32'h8000_0000; win[1] = -32'sd1; win[2] = -32'sd1025;
        send(3);
        do_tick(-32768, 0); do_tick(-1, 0); do_tick(-2, 0);

        // Zero length ignored, then clamped length
        pulse_done(0);
        @(negedge clk_in);
        chk("t5_zero_busy", busy_o, 0);
        chk("t5_zero_ovf", ovf_o, 0);
        @(negedge clk_in);
        chk("t5_zero_busy2", busy_o, 0);
        for (int k = 0; k < DEPTH; k++) win[k] = (k * 37 - 30000) * 1024 + (k % 1024);
        send(4095);
        for (int k = 0; k < DEPTH; k++) do_tick(sat16(k * 37 - 30000), 0);
        chk("t5_playing_end", playing_o, 0);
        do_tick(0, 1);

        // Reset during play
        win[0] = 32'sd1024; win[1] = 32'sd2048; win[2] = 32'sd3072; win[3] = 32'sd4096;
        send(4);
        do_tick(1, 0);
        do_tick(2, 0);
        chk("t6_playing_pre", playing_o, 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("t6_rst_sample", sample_o, 0);
        chk("t6_rst_playing", playing_o, 0);
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        @(negedge clk_in) rst_n_in = 1'b1;
        do_tick(0, 1);

        repeat (4) @(posedge clk_in);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
